startup_sequencer: RTL and testbench
====================================

STARTUP_SEQUENCER -- requirements
Module: startup_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of downstream stages released in order (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 15: cycles all stage resets stay asserted after reset deasserts (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for one stage's ready (>=1).
REQ-004 SHALL have parameter COUNTER_WIDTH, default 8: width of the internal cycle counter; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).
REQ-005 SHALL have parameter IDX_WIDTH, default 2: width of error_stage; must hold NUM_STAGES-1.
REQ-006 SHALL have port clock_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset (driven by the power-on reset generator).
REQ-008 SHALL have port stage_ready, input, NUM_STAGES bits: per-stage "initialised" acknowledge, level-sensitive.
REQ-009 SHALL have port rerun, input, 1 bit: single-cycle request to restart the sequence from DONE or FAULT.
REQ-010 SHALL have port stage_reset, output, NUM_STAGES bits: per-stage active-high reset; registered.
REQ-011 SHALL have port all_ready, output, 1 bit: high while every stage is released and acknowledged.
REQ-012 SHALL have port error, output, 1 bit: high while in FAULT.
REQ-013 SHALL have port error_stage, output, IDX_WIDTH bits: index of the stage that caused FAULT.

Function
REQ-014 SHALL implement FSM states HOLD, WAIT, DONE, FAULT; all outputs registered.
REQ-015 HOLD SHALL keep all stage_reset bits at 1 and increment the counter each cycle. When the counter equals HOLD_CYCLES-1, the FSM SHALL go to WAIT with stage index 0, clear stage_reset[0] and zero the counter. stage_reset[0] therefore falls exactly HOLD_CYCLES cycles after the first cycle with reset low.
REQ-016 WAIT SHALL sample stage_ready[idx] each cycle. If it is high and idx < NUM_STAGES-1, the FSM SHALL increment idx, clear stage_reset[idx+1] on the same edge, zero the counter and stay in WAIT.
REQ-017 WAIT with stage_ready[idx] high and idx = NUM_STAGES-1 SHALL go to DONE and set all_ready to 1 on that edge.
REQ-018 WAIT with stage_ready[idx] low SHALL increment the counter. On the cycle the counter equals TIMEOUT_CYCLES-1, the FSM SHALL go to FAULT with error=1, error_stage=idx, and all stage_reset bits reasserted to 1.
REQ-019 In WAIT, a ready and a timeout in the same cycle SHALL resolve as ready (no fault).
REQ-020 In WAIT, stage_ready bits for stages other than idx SHALL be ignored. This includes early readies from stages not yet released.
REQ-021 In DONE, if any stage_ready bit is low, the FSM SHALL go to FAULT. On that edge: all_ready=0, error=1, error_stage = lowest index with ready low, all stage_reset bits set to 1.
REQ-022 In DONE or FAULT, rerun=1 SHALL go to HOLD with all_ready=0, error=0, error_stage=0, all stage_reset bits 1, counter 0, idx 0. rerun SHALL take priority over the DONE ready-drop check in the same cycle.
REQ-023 rerun SHALL be ignored in HOLD and WAIT.
REQ-024 FAULT SHALL hold error, error_stage and stage_reset steady until rerun or reset.
REQ-025 Counter arithmetic SHALL be unsigned COUNTER_WIDTH bits and SHALL never wrap: every state entry zeroes it.
REQ-026 Stages SHALL be released strictly in ascending index order, at most one newly released stage per cycle.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL enter HOLD with all stage_reset bits 1, all_ready 0, error 0, error_stage 0, counter 0 and idx 0. This SHALL apply regardless of state.
REQ-028 While reset remains high, the block SHALL remain in HOLD with the counter held at 0.
REQ-029 reset SHALL take priority over rerun and over all stage_ready activity.

Verification (defaults: NUM_STAGES=3, HOLD_CYCLES=15, TIMEOUT_CYCLES=255)
REQ-030 Nominal: reset high 3 cycles then low; each stage_ready rises 2 cycles after its stage_reset falls.
- stage_reset 3'b111 -> 3'b110 at cycle 15.
- stage_reset -> 3'b100 at cycle 18.
- stage_reset -> 3'b000 at cycle 21.
- all_ready=1 at cycle 24.
REQ-031 Timeout: stage 1 never acknowledges.
- FAULT entered 255 cycles after stage_reset[1] falls.
- error=1, error_stage=1, stage_reset=3'b111, all_ready=0.
REQ-032 Ready-drop: in DONE, force stage_ready=3'b101 for one cycle.
- Next edge: error=1, error_stage=1, all_ready=0, stage_reset=3'b111.
REQ-033 Rerun: from FAULT, pulse rerun one cycle.
- error=0 on the next edge.
- Sequence repeats with stage_reset[0] falling 15 cycles after HOLD entry.
REQ-034 Reset mid-sequence: assert reset while in WAIT at idx=1.
- Next edge: stage_reset=3'b111, all_ready=0, error=0.
- After release, timing is identical to REQ-030.
REQ-035 Simultaneous events and early readies:
- Stage 0 ready arrives exactly on the timeout cycle -> no fault; stage_reset[1] falls.
- All stage_ready bits held high from time 0 -> stages still release one per cycle: cycles 15, 16, 17, all_ready at cycle 18.

Source files
------------

// File: rtl/startup_sequencer.sv
// Power-up release sequencer: holds every downstream stage in reset, then releases
// them one at a time in ascending order, waiting for each stage's ready acknowledge.
module startup_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 15,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 8,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  rerun,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_ready,
  output logic                  error,
  output logic [IDX_WIDTH-1:0]  error_stage
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST    = COUNTER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO     = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE      = COUNTER_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]     IDX_ZERO     = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0]     IDX_ONE      = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]     IDX_LAST     = IDX_WIDTH'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0]    ALL_ONES     = {NUM_STAGES{1'b1}};

  state_t                  state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
  logic                    all_ready_q, all_ready_d;
  logic                    error_q, error_d;
  logic [IDX_WIDTH-1:0]    error_stage_q, error_stage_d;
  logic                    ready_sel;
  logic [IDX_WIDTH-1:0]    idx_inc;

  // Ready of the stage currently being waited on; every other bit is ignored.
  function automatic logic select_ready(input logic [NUM_STAGES-1:0] rdy,
                                        input logic [IDX_WIDTH-1:0]  idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      r = (IDX_WIDTH'(i) == idx) ? rdy[i] : r;
    end
    return r;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] lowest_low(input logic [NUM_STAGES-1:0] rdy);
    logic [IDX_WIDTH-1:0] r;
    r = IDX_ZERO;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      r = rdy[i] ? r : IDX_WIDTH'(i);
    end
    return r;
  endfunction

  // Stages 0..idx released (reset low), all higher stages still held.
  function automatic logic [NUM_STAGES-1:0] release_mask(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_STAGES-1:0] m;
    m = ALL_ONES;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (IDX_WIDTH'(i) > idx) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  assign ready_sel = select_ready(stage_ready, idx_q);
  assign idx_inc   = idx_q + IDX_ONE;

  // Next-state and next-output logic for the release sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    all_ready_d   = all_ready_q;
    error_d       = error_q;
    error_stage_d = error_stage_q;

    case (state_q)
      ST_HOLD: begin
        stage_reset_d = ALL_ONES;
        if (cnt_q == HOLD_LAST) begin
          state_d       = ST_WAIT;
          idx_d         = IDX_ZERO;
          cnt_d         = CNT_ZERO;
          stage_reset_d = release_mask(IDX_ZERO);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT: begin
        // A ready seen on the timeout cycle still counts as success.
        if (ready_sel) begin
          cnt_d = CNT_ZERO;
          if (idx_q == IDX_LAST) begin
            state_d     = ST_DONE;
            all_ready_d = 1'b1;
          end else begin
            idx_d         = idx_inc;
            stage_reset_d = release_mask(idx_inc);
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_FAULT;
          cnt_d         = CNT_ZERO;
          error_d       = 1'b1;
          error_stage_d = idx_q;
          stage_reset_d = ALL_ONES;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        if (rerun) begin
          state_d       = ST_HOLD;
          cnt_d         = CNT_ZERO;
          idx_d         = IDX_ZERO;
          stage_reset_d = ALL_ONES;
          all_ready_d   = 1'b0;
          error_d       = 1'b0;
          error_stage_d = IDX_ZERO;
        end else if (stage_ready != ALL_ONES) begin
          state_d       = ST_FAULT;
          cnt_d         = CNT_ZERO;
          stage_reset_d = ALL_ONES;
          all_ready_d   = 1'b0;
          error_d       = 1'b1;
          error_stage_d = lowest_low(stage_ready);
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_FAULT: begin
        if (rerun) begin
          state_d       = ST_HOLD;
          cnt_d         = CNT_ZERO;
          idx_d         = IDX_ZERO;
          stage_reset_d = ALL_ONES;
          all_ready_d   = 1'b0;
          error_d       = 1'b0;
          error_stage_d = IDX_ZERO;
        end else begin
          state_d = ST_FAULT;
        end
      end

      default: begin
        state_d       = ST_HOLD;
        cnt_d         = CNT_ZERO;
        idx_d         = IDX_ZERO;
        stage_reset_d = ALL_ONES;
        all_ready_d   = 1'b0;
        error_d       = 1'b0;
        error_stage_d = IDX_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset back into HOLD.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      cnt_q         <= CNT_ZERO;
      idx_q         <= IDX_ZERO;
      stage_reset_q <= ALL_ONES;
      all_ready_q   <= 1'b0;
      error_q       <= 1'b0;
      error_stage_q <= IDX_ZERO;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      all_ready_q   <= all_ready_d;
      error_q       <= error_d;
      error_stage_q <= error_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign all_ready   = all_ready_q;
  assign error       = error_q;
  assign error_stage = error_stage_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: directed timing scenarios with absolute cycle checks,
// then randomized stimulus, all compared each cycle against a count-based model.
module tb_startup_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 15;
  localparam int TMO  = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rerun = 1'b0;
  logic [N-1:0] stage_ready = '0;
  logic [N-1:0] stage_reset;
  logic         all_ready;
  logic         error;
  logic [1:0]   error_stage;

  int tests_run    = 0;
  int tests_failed = 0;

  // model: number of released stages, cycles spent in the current phase, flags
  int m_rel;
  int m_elapsed;
  bit m_done;
  bit m_fault;
  int m_fstage;

  always #5 clk = ~clk;

  startup_sequencer #(
    .NUM_STAGES(N), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO),
    .COUNTER_WIDTH(8), .IDX_WIDTH(2)
  ) dut (
    .clock_in(clk), .reset(reset), .stage_ready(stage_ready), .rerun(rerun),
    .stage_reset(stage_reset), .all_ready(all_ready), .error(error),
    .error_stage(error_stage)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_init();
    m_rel = 0; m_elapsed = 0; m_done = 1'b0; m_fault = 1'b0; m_fstage = 0;
  endtask

  task automatic model_step(input bit r, input bit rr, input logic [N-1:0] rdy);
    if (r) begin
      model_init();
    end else if (m_fault) begin
      if (rr) model_init();
    end else if (m_done) begin
      if (rr) begin
        model_init();
      end else if (rdy != {N{1'b1}}) begin
        m_fault = 1'b1; m_done = 1'b0; m_rel = 0;
        for (int i = N - 1; i >= 0; i--) if (!rdy[i]) m_fstage = i;
      end
    end else if (m_rel == 0) begin
      m_elapsed++;
      if (m_elapsed == HOLD) begin m_rel = 1; m_elapsed = 0; end
    end else if (rdy[m_rel-1]) begin
      m_elapsed = 0;
      if (m_rel == N) m_done = 1'b1;
      else m_rel++;
    end else begin
      m_elapsed++;
      if (m_elapsed == TMO) begin
        m_fault = 1'b1; m_fstage = m_rel - 1; m_rel = 0; m_elapsed = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_stage_reset();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = m_fault ? 1'b1 : (i >= m_rel);
    return e;
  endfunction

  task automatic tick();
    model_step(reset, rerun, stage_ready);
    @(posedge clk);
    #1;
    check_eq("model_stage_reset", stage_reset, exp_stage_reset());
    check_eq("model_all_ready", all_ready, m_done);
    check_eq("model_error", error, m_fault);
    check_eq("model_error_stage", error_stage, m_fstage);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; rerun = 1'b0;
    repeat (n) tick();
    check_eq("rst_stage_reset", stage_reset, 3'b111);
    check_eq("rst_all_ready", all_ready, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_error_stage", error_stage, 2'd0);
    reset = 1'b0;
  endtask

  // Each stage_ready rises 2 cycles after its stage_reset falls (cycle c = ticks since reset low).
  task automatic nominal();
    int c;
    for (int k = 0; k < 26; k++) begin
      for (int s = 0; s < N; s++) stage_ready[s] = (k >= 17 + 3 * s);
      tick();
      c = k + 1;
      if (c == 14) check_eq("nom_sr_c14", stage_reset, 3'b111);
      if (c == 15) check_eq("nom_sr_c15", stage_reset, 3'b110);
      if (c == 17) check_eq("nom_sr_c17", stage_reset, 3'b110);
      if (c == 18) check_eq("nom_sr_c18", stage_reset, 3'b100);
      if (c == 20) check_eq("nom_sr_c20", stage_reset, 3'b100);
      if (c == 21) check_eq("nom_sr_c21", stage_reset, 3'b000);
      if (c == 23) check_eq("nom_ar_c23", all_ready, 1'b0);
      if (c == 24) check_eq("nom_ar_c24", all_ready, 1'b1);
    end
  endtask

  initial begin
    int c;
    int mode;
    model_init();

    // nominal release
    do_reset(3);
    nominal();

    // ready drop in DONE
    stage_ready = 3'b101;
    tick();
    check_eq("drop_error", error, 1'b1);
    check_eq("drop_error_stage", error_stage, 2'd1);
    check_eq("drop_all_ready", all_ready, 1'b0);
    check_eq("drop_stage_reset", stage_reset, 3'b111);
    stage_ready = 3'b111;
    repeat (5) tick();
    check_eq("fault_hold_error", error, 1'b1);
    check_eq("fault_hold_stage", error_stage, 2'd1);

    // rerun from FAULT, all readies already high
    rerun = 1'b1;
    tick();
    rerun = 1'b0;
    check_eq("rerun_error", error, 1'b0);
    check_eq("rerun_stage_reset", stage_reset, 3'b111);
    for (int k = 0; k < 19; k++) begin
      tick();
      c = k + 1;
      if (c == 14) check_eq("rr_sr_c14", stage_reset, 3'b111);
      if (c == 15) check_eq("rr_sr_c15", stage_reset, 3'b110);
      if (c == 16) check_eq("rr_sr_c16", stage_reset, 3'b100);
      if (c == 17) check_eq("rr_sr_c17", stage_reset, 3'b000);
      if (c == 17) check_eq("rr_ar_c17", all_ready, 1'b0);
      if (c == 18) check_eq("rr_ar_c18", all_ready, 1'b1);
    end

    // timeout on stage 1
    stage_ready = 3'b000;
    do_reset(2);
    stage_ready = 3'b001;
    for (int k = 0; k < 276; k++) begin
      tick();
      c = k + 1;
      if (c == 16) check_eq("tmo_sr_c16", stage_reset, 3'b100);
      if (c == 270) check_eq("tmo_err_c270", error, 1'b0);
      if (c == 270) check_eq("tmo_sr_c270", stage_reset, 3'b100);
      if (c == 271) check_eq("tmo_err_c271", error, 1'b1);
      if (c == 271) check_eq("tmo_es_c271", error_stage, 2'd1);
      if (c == 271) check_eq("tmo_sr_c271", stage_reset, 3'b111);
      if (c == 271) check_eq("tmo_ar_c271", all_ready, 1'b0);
    end

    // reset while waiting on stage 1; rerun ignored in WAIT
    stage_ready = 3'b000;
    do_reset(2);
    stage_ready = 3'b001;
    repeat (40) tick();
    rerun = 1'b1;
    tick();
    rerun = 1'b0;
    check_eq("wait_rerun_ignored", stage_reset, 3'b100);
    reset = 1'b1;
    tick();
    check_eq("midrst_sr", stage_reset, 3'b111);
    check_eq("midrst_ar", all_ready, 1'b0);
    check_eq("midrst_err", error, 1'b0);
    reset = 1'b0;
    stage_ready = 3'b000;
    nominal();

    // stage 0 ready exactly on the timeout cycle
    stage_ready = 3'b000;
    do_reset(2);
    for (int k = 0; k < 273; k++) begin
      stage_ready[0] = (k == 269);
      tick();
      c = k + 1;
      if (c == 269) check_eq("sim_sr_c269", stage_reset, 3'b110);
      if (c == 270) check_eq("sim_sr_c270", stage_reset, 3'b100);
      if (c == 270) check_eq("sim_err_c270", error, 1'b0);
    end

    // all readies high from reset: one release per cycle
    stage_ready = 3'b111;
    do_reset(2);
    for (int k = 0; k < 20; k++) begin
      tick();
      c = k + 1;
      if (c == 15) check_eq("early_sr_c15", stage_reset, 3'b110);
      if (c == 16) check_eq("early_sr_c16", stage_reset, 3'b100);
      if (c == 17) check_eq("early_sr_c17", stage_reset, 3'b000);
      if (c == 17) check_eq("early_ar_c17", all_ready, 1'b0);
      if (c == 18) check_eq("early_ar_c18", all_ready, 1'b1);
    end

    // randomized traffic against the model
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 300 == 0) mode = $urandom_range(0, 2);
      reset = ($urandom_range(0, 299) == 0);
      rerun = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < N; s++) begin
        case (mode)
          0: stage_ready[s] = ($urandom_range(0, 3) != 0);
          1: stage_ready[s] = ($urandom_range(0, 59) != 0);
          default: stage_ready[s] = ($urandom_range(0, 9) == 0);
        endcase
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
